// File: rtl/aes_io_pkg.sv
// Shared types and sizing for the AES byte-stream input and output blocks.
// INPUT_KEY_EN widens a block to key+plaintext (32 bytes) and the byte counter to match.
package aes_io_pkg;

    typedef enum logic [1:0] {
        WAIT_DATA = 2'd0,
        ACK       = 2'd1,
        FULL      = 2'd2
    } io_state_e;

    localparam int BLOCK_BYTES = 16;
    localparam int KEY_BYTES   = 16;

`ifdef INPUT_KEY_EN
    localparam int TOTAL_BYTES = KEY_BYTES + BLOCK_BYTES;
`else
    localparam int TOTAL_BYTES = BLOCK_BYTES;
`endif

    // Wide enough to hold TOTAL_BYTES itself, so a full block never wraps to 0.
    localparam int CNT_W = $clog2(TOTAL_BYTES + 1);

endpackage

// File: rtl/input_interface_if.sv
// Byte-source and block-sink signal bundle of input_interface; slave is the DUT side.
// INPUT_KEY_EN adds the 128-bit key output alongside plaintext.
interface input_interface_if;
    import aes_io_pkg::*;

    logic [7:0]       data_in;
    logic             data_ok;
    logic             input_read;
    logic [127:0]     plaintext;
    logic             block_valid;
    logic             block_ack;
    logic [CNT_W-1:0] byte_count;
`ifdef INPUT_KEY_EN
    logic [127:0]     key;
`endif

    modport slave (
        input  data_in, data_ok, block_ack,
        output input_read, plaintext, block_valid, byte_count
`ifdef INPUT_KEY_EN
        , output key
`endif
    );

    modport master (
        output data_in, data_ok, block_ack,
        input  input_read, plaintext, block_valid, byte_count
`ifdef INPUT_KEY_EN
        , input key
`endif
    );

endinterface

// File: rtl/input_shift_reg.sv
// Byte-slot block register: each slot loads wr_dat on the cycle after its write enable.
// No backpressure of its own; slots hold until rewritten or reset.
module input_shift_reg #(
    parameter int NUM_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NUM_BYTES-1:0]   slot_we_i,
    input  logic [7:0]             wr_dat_i,
    output logic [NUM_BYTES*8-1:0] slots_o
);

    logic [NUM_BYTES*8-1:0] slots_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            slots_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (slot_we_i[i]) slots_q[i*8 +: 8] <= wr_dat_i;
            end
        end
    end

    assign slots_o = slots_q;

endmodule

// File: rtl/input_interface.sv
// Assembles bytes from a 4-phase data_ok/input_read source into a block; ack one cycle after capture.
// Holds the block with block_valid until block_ack; source stalls in the meantime. INPUT_KEY_EN: 32-byte key+plaintext block.
module input_interface
    import aes_io_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_,
    input_interface_if.slave   bus
);

    io_state_e                   state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        input_read_q;
    logic                        block_valid_q;
    logic                        capture;
    logic [CNT_W-1:0]            slot_idx;
    logic [TOTAL_BYTES-1:0]      slot_we;
    logic [TOTAL_BYTES*8-1:0]    slots;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            WAIT_DATA: begin
                if (bus.data_ok) begin
                    capture = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!bus.data_ok) begin
                    state_d = (cnt_q == CNT_W'(TOTAL_BYTES)) ? FULL : WAIT_DATA;
                end
            end
            FULL: begin
                // data_ok is deliberately ignored here; a coincident byte waits for WAIT_DATA.
                if (bus.block_ack) begin
                    cnt_d   = '0;
                    state_d = WAIT_DATA;
                end
            end
            default: state_d = WAIT_DATA;
        endcase
    end

    // Slot layout: byte i sits at slot i (LSB-first) or mirrored from the top (MSB-first).
    assign slot_idx = MSB_FIRST ? (CNT_W'(TOTAL_BYTES - 1) - cnt_q) : cnt_q;

    always_comb begin
        slot_we = '0;
        for (int i = 0; i < TOTAL_BYTES; i++) begin
            slot_we[i] = capture && (slot_idx == CNT_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q       <= WAIT_DATA;
            cnt_q         <= '0;
            input_read_q  <= 1'b0;
            block_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            input_read_q  <= (state_d == ACK);
            block_valid_q <= (state_d == FULL);
        end
    end

    input_shift_reg #(
        .NUM_BYTES (TOTAL_BYTES)
    ) u_shift_reg (
        .clk       (clk),
        .rst_      (rst_),
        .slot_we_i (slot_we),
        .wr_dat_i  (bus.data_in),
        .slots_o   (slots)
    );

    assign bus.input_read  = input_read_q;
    assign bus.block_valid = block_valid_q;
    assign bus.byte_count  = cnt_q;

`ifdef INPUT_KEY_EN
    // Key occupies bytes 0-15, so it is the upper half when MSB-first and the lower half otherwise.
    assign {bus.key, bus.plaintext} = MSB_FIRST ? slots : {slots[127:0], slots[255:128]};
`else
    assign bus.plaintext = slots;
`endif

endmodule

// File: tb/tb_input_interface.sv
// Drives an MSB-first and an LSB-first input_interface with the same byte stream and
// compares both against a byte-array model of the block being assembled.
module tb_input_interface;
    import aes_io_pkg::*;

    logic       clk = 1'b0;
    logic       rst_;
    logic [7:0] data_in;
    logic       data_ok;
    logic       block_ack;

    always #5 clk = ~clk;

    input_interface_if if_m ();
    input_interface_if if_l ();

    assign if_m.data_in   = data_in;
    assign if_m.data_ok   = data_ok;
    assign if_m.block_ack = block_ack;
    assign if_l.data_in   = data_in;
    assign if_l.data_ok   = data_ok;
    assign if_l.block_ack = block_ack;

    input_interface #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_(rst_), .bus(if_m.slave));
    input_interface #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_(rst_), .bus(if_l.slave));

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mdl [TOTAL_BYTES];
    int         mcnt;
    bit         mfull;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] field(input bit msb, input int base);
        logic [127:0] f;
        f = '0;
        for (int j = 0; j < 16; j++) begin
            if (msb) f[127 - 8*j -: 8] = mdl[base + j];
            else     f[8*j +: 8]       = mdl[base + j];
        end
        return f;
    endfunction

    task automatic compare_state(input string tag);
        check({tag, "_cnt_m"}, if_m.byte_count, mcnt);
        check({tag, "_cnt_l"}, if_l.byte_count, mcnt);
        check({tag, "_vld_m"}, if_m.block_valid, mfull);
        check({tag, "_vld_l"}, if_l.block_valid, mfull);
        check({tag, "_pt_m"}, if_m.plaintext, field(1'b1, TOTAL_BYTES - 16));
        check({tag, "_pt_l"}, if_l.plaintext, field(1'b0, TOTAL_BYTES - 16));
`ifdef INPUT_KEY_EN
        check({tag, "_key_m"}, if_m.key, field(1'b1, 0));
        check({tag, "_key_l"}, if_l.key, field(1'b0, 0));
`endif
    endtask

    task automatic model_clear();
        for (int i = 0; i < TOTAL_BYTES; i++) mdl[i] = 8'h00;
        mcnt  = 0;
        mfull = 1'b0;
    endtask

    task automatic model_push(input logic [7:0] b);
        mdl[mcnt] = b;
        mcnt++;
        if (mcnt == TOTAL_BYTES) mfull = 1'b1;
    endtask

    // One 4-phase transfer; inputs change on falling edges, outputs sampled there too.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        int lat;
        repeat (gap) begin
            block_ack = ($urandom_range(0, 1) == 1) && !mfull;
            @(negedge clk);
        end
        block_ack = 1'b0;
        data_in   = b;
        data_ok   = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if_m.input_read && lat < 20);
        check("rd_latency", lat, 1);
        check("rd_l", if_l.input_read, 1'b1);
        check("ack_cnt", if_m.byte_count, mcnt + 1);
        repeat (hold) begin
            block_ack = $urandom_range(0, 1);
            @(negedge clk);
        end
        block_ack = 1'b0;
        check("held_cnt", if_l.byte_count, mcnt + 1);
        check("held_rd", if_m.input_read, 1'b1);
        data_ok = 1'b0;
        model_push(b);
        @(negedge clk);
        check("rd_drop", {if_m.input_read, if_l.input_read}, 2'b00);
        compare_state("byte");
    endtask

    task automatic ack_only();
        block_ack = 1'b1;
        @(negedge clk);
        block_ack = 1'b0;
        mcnt  = 0;
        mfull = 1'b0;
        compare_state("ack");
    endtask

    // Byte offered throughout FULL is refused, then taken as byte 0 right after the ack.
    task automatic full_hold_then_ack(input logic [7:0] b);
        logic seen;
        seen    = 1'b0;
        data_in = b;
        data_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            seen = seen | if_m.input_read | if_l.input_read;
        end
        check("full_rd", seen, 1'b0);
        compare_state("full_hold");
        block_ack = 1'b1;
        @(negedge clk);
        block_ack = 1'b0;
        mcnt  = 0;
        mfull = 1'b0;
        check("post_ack_rd", if_m.input_read, 1'b0);
        compare_state("post_ack");
        @(negedge clk);
        model_push(b);
        check("late_capt_rd", if_m.input_read, 1'b1);
        compare_state("late_capt");
        data_ok = 1'b0;
        @(negedge clk);
        check("late_capt_drop", if_l.input_read, 1'b0);
    endtask

    task automatic do_reset(input bit ok_at_release, input logic [7:0] b);
        data_in = b;
        data_ok = ok_at_release;
        #1 rst_ = 1'b0;
        #1;
        model_clear();
        compare_state("rst_async");
        @(negedge clk);
        rst_ = 1'b1;
        if (ok_at_release) begin
            @(negedge clk);
            model_push(b);
            check("rel_rd", if_m.input_read, 1'b1);
            compare_state("rel_capt");
            data_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic fill_random();
        while (mcnt < TOTAL_BYTES) begin
            send_byte(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    logic [7:0] v29 [16] = '{8'hBC, 8'h02, 8'h8B, 8'hD3, 8'hE0, 8'hE3, 8'hB1, 8'h95,
                             8'h55, 8'h0D, 8'h6D, 8'hF8, 8'hE6, 8'hF1, 8'h82, 8'h41};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_      = 1'b0;
        data_in   = 8'h00;
        data_ok   = 1'b0;
        block_ack = 1'b0;
        model_clear();
        #1;
        compare_state("reset");
        check("reset_rd", {if_m.input_read, if_l.input_read}, 2'b00);
        repeat (2) @(negedge clk);
        rst_ = 1'b1;

        // Ascending pattern block
        for (int i = 0; i < TOTAL_BYTES; i++) begin
`ifdef INPUT_KEY_EN
            send_byte(8'(i), 0, 0);
`else
            send_byte(8'(i * 17), 0, 0);
`endif
        end
`ifdef INPUT_KEY_EN
        check("key_const", if_m.key, 128'h000102030405060708090A0B0C0D0E0F);
        check("pt_const", if_m.plaintext, 128'h101112131415161718191A1B1C1D1E1F);
`else
        check("pt_msb_const", if_m.plaintext, 128'h00112233445566778899AABBCCDDEEFF);
`endif
        check("vld_const", if_m.block_valid, 1'b1);
        full_hold_then_ack(8'hAA);

        // LSB-first reference block
        do_reset(1'b0, 8'h00);
        for (int i = 0; i < TOTAL_BYTES - 16; i++) send_byte(8'($urandom), 1, 0);
        for (int i = 0; i < 16; i++) send_byte(v29[i], $urandom_range(0, 2), 0);
`ifndef INPUT_KEY_EN
        check("pt_lsb_const", if_l.plaintext, 128'h4182F1E6F86D0D5595B1E3E0D38B02BC);
`endif
        ack_only();

        // Long data_ok high period, then reset mid-block with data_ok high at release
        send_byte(8'h3C, 3, 0);
        check("long_cnt", if_m.byte_count, 1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), $urandom_range(0, 3), 1);
        do_reset(1'b1, 8'($urandom));
        fill_random();
        ack_only();

        // Random blocks with both release styles
        for (int k = 0; k < 3; k++) begin
            fill_random();
            if (k == 1) full_hold_then_ack(8'($urandom));
            else        ack_only();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
